// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: loads a pattern word over valid/ready and shifts it
// MSB-first onto a 1-bit line, repeating passes back-to-back with no gap.
module seq_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int LEN_W = $clog2(WIDTH + 1),
  parameter int RPT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LEN_W-1:0] load_len,
  input  logic [RPT_W-1:0] load_rpt,
  input  logic             abort,
  output logic             out_seq,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [RPT_W-1:0] RPT_ONE = RPT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_data, w_data_nxt;
  logic [LEN_W-1:0] r_len, w_len_nxt;
  logic [LEN_W-1:0] r_idx, w_idx_nxt;
  logic [RPT_W-1:0] r_rpt_left, w_rpt_left_nxt;
  logic             r_out_seq, w_out_seq_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_load_ready, w_load_ready_nxt;

  logic             w_accept;
  logic [LEN_W-1:0] w_load_len;
  logic [LEN_W-1:0] w_load_msb;
  logic [LEN_W-1:0] w_shift_idx;
  logic             w_load_bit;
  logic             w_shift_bit;

  assign w_accept    = load_valid && r_load_ready;
  // Zero or oversized lengths fall back to the full pattern width.
  assign w_load_len  = (load_len == '0 || load_len > LEN_MAX) ? LEN_MAX : load_len;
  assign w_load_msb  = w_load_len - LEN_ONE;
  // r_idx names the bit on the line now; index 0 wraps to the MSB for the next pass.
  assign w_shift_idx = (r_idx == '0) ? (r_len - LEN_ONE) : (r_idx - LEN_ONE);

  always_comb begin
    w_load_bit  = 1'b0;
    w_shift_bit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_load_msb == LEN_W'(i))  w_load_bit  = load_data[i];
      if (w_shift_idx == LEN_W'(i)) w_shift_bit = r_data[i];
    end
  end

  always_comb begin
    // NOTE: every next-value gets a default before the case so no path leaves a signal unassigned (no latches).
    w_state_nxt      = r_state;
    w_data_nxt       = r_data;
    w_len_nxt        = r_len;
    w_idx_nxt        = r_idx;
    w_rpt_left_nxt   = r_rpt_left;
    w_out_seq_nxt    = 1'b0;
    w_out_valid_nxt  = 1'b0;
    w_busy_nxt       = r_busy;
    w_done_nxt       = 1'b0;
    w_load_ready_nxt = r_load_ready;

    unique case (r_state)
      S_IDLE: begin
        w_busy_nxt       = 1'b0;
        w_load_ready_nxt = 1'b1;
        if (w_accept) begin
          w_data_nxt       = load_data;
          w_len_nxt        = w_load_len;
          w_idx_nxt        = w_load_msb;
          w_rpt_left_nxt   = load_rpt;
          w_out_seq_nxt    = w_load_bit;
          w_out_valid_nxt  = 1'b1;
          w_busy_nxt       = 1'b1;
          w_load_ready_nxt = 1'b0;
          w_state_nxt      = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (abort) begin
          w_busy_nxt       = 1'b0;
          w_load_ready_nxt = 1'b1;
          w_state_nxt      = S_IDLE;
        end else if (r_idx == '0 && r_rpt_left == '0) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          if (r_idx == '0) w_rpt_left_nxt = r_rpt_left - RPT_ONE;
          w_idx_nxt       = w_shift_idx;
          w_out_seq_nxt   = w_shift_bit;
          w_out_valid_nxt = 1'b1;
        end
      end

      S_DONE: begin
        w_busy_nxt       = 1'b0;
        w_load_ready_nxt = 1'b1;
        w_state_nxt      = S_IDLE;
      end

      default: begin
        w_busy_nxt       = 1'b0;
        w_load_ready_nxt = 1'b0;
        w_state_nxt      = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_data       <= '0;
      r_len        <= '0;
      r_idx        <= '0;
      r_rpt_left   <= '0;
      r_out_seq    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_load_ready <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_data       <= w_data_nxt;
      r_len        <= w_len_nxt;
      r_idx        <= w_idx_nxt;
      r_rpt_left   <= w_rpt_left_nxt;
      r_out_seq    <= w_out_seq_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_load_ready <= w_load_ready_nxt;
    end
  end

  assign out_seq    = r_out_seq;
  assign out_valid  = r_out_valid;
  assign busy       = r_busy;
  assign done       = r_done;
  assign load_ready = r_load_ready;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: a driver pushes expected bit streams and burst endings
// into queues; an independent monitor pops and compares them against the DUT.
module tb_seq_pattern_tx;

  localparam int WIDTH = 8;
  localparam int LEN_W = 4;
  localparam int RPT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             load_valid = 1'b0;
  logic             load_ready;
  logic [WIDTH-1:0] load_data = '0;
  logic [LEN_W-1:0] load_len = '0;
  logic [RPT_W-1:0] load_rpt = '0;
  logic             abort = 1'b0;
  logic             out_seq, out_valid, busy, done;

  seq_pattern_tx #(.WIDTH(WIDTH), .LEN_W(LEN_W), .RPT_W(RPT_W)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_len(load_len), .load_rpt(load_rpt),
    .abort(abort),
    .out_seq(out_seq), .out_valid(out_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n;      // valid bits expected in the burst
    bit done;   // done pulse (and busy) expected when the burst ends
    bit ready;  // load_ready expected when the burst ends
    int det;    // overlapping "101" matches expected in the burst
  } burst_t;

  bit     exp_bits[$];
  burst_t exp_end[$];
  int     vectors = 0;
  int     miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the stream is the pattern read MSB-first, cycled (rpt+1) times.
  function automatic int clamp_len(input logic [LEN_W-1:0] l);
    return (l == 0 || l > WIDTH) ? WIDTH : int'(l);
  endfunction

  function automatic bit exp_bit(input logic [WIDTH-1:0] d, input int len, input int i);
    logic [WIDTH-1:0] t;
    t = d >> (len - 1 - (i % len));
    return t[0];
  endfunction

  function automatic int count_101(input logic [WIDTH-1:0] d, input int len, input int kept);
    int c = 0;
    for (int i = 2; i < kept; i++)
      if (exp_bit(d, len, i - 2) && !exp_bit(d, len, i - 1) && exp_bit(d, len, i)) c++;
    return c;
  endfunction

  // Monitor: compares every valid bit and the shape of every burst ending.
  initial begin : monitor
    bit         prev_valid = 1'b0;
    int         run = 0;
    int         det = 0;
    logic [2:0] hist = '0;
    burst_t     b;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (exp_bits.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_bit: got out_seq=%0b with no bit expected (t=%0t)", out_seq, $time);
        end else begin
          check("out_seq", out_seq, exp_bits.pop_front());
        end
        check("busy_while_valid", busy, 1);
        check("ready_while_valid", load_ready, 0);
        hist = {hist[1:0], out_seq};
        run++;
        if (run >= 3 && hist == 3'b101) det++;
      end else begin
        check("idle_out_seq", out_seq, 0);
        if (prev_valid) begin
          if (exp_end.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_burst_end: got burst of %0d bits, expected none (t=%0t)", run, $time);
          end else begin
            b = exp_end.pop_front();
            check("burst_len", run, b.n);
            check("done_at_end", done, b.done);
            check("busy_at_end", busy, b.done);
            check("ready_at_end", load_ready, b.ready);
            check("detections_101", det, b.det);
          end
          run  = 0;
          det  = 0;
          hist = '0;
        end else begin
          check("spurious_done", done, 0);
        end
      end
      prev_valid = out_valid;
    end
  end

  // Issues one pattern; abort_k >= 0 aborts while bit abort_k of the stream is on the line.
  task automatic send(input logic [WIDTH-1:0] d, input logic [LEN_W-1:0] l,
                      input logic [RPT_W-1:0] r, input int abort_k, input bit keep_valid);
    int     len, total, kept, guard, cnt;
    burst_t b;
    len   = clamp_len(l);
    total = len * (int'(r) + 1);
    kept  = (abort_k >= 0) ? abort_k + 1 : total;
    guard = 0;
    while (!load_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("ready_wait", load_ready, 1);
    if (!load_ready) return;
    load_valid = 1'b1;
    load_data  = d;
    load_len   = l;
    load_rpt   = r;
    for (int i = 0; i < kept; i++) exp_bits.push_back(exp_bit(d, len, i));
    b.n = kept; b.done = (abort_k < 0); b.ready = (abort_k >= 0); b.det = count_101(d, len, kept);
    exp_end.push_back(b);
    @(posedge clk); #1;
    if (keep_valid) begin
      load_data = WIDTH'($urandom);
      load_len  = LEN_W'($urandom);
      load_rpt  = RPT_W'($urandom);
    end else begin
      load_valid = 1'b0;
    end
    if (abort_k >= 0) begin
      repeat (abort_k) begin @(posedge clk); #1; end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      check("ready_after_abort", load_ready, 1);
      check("busy_after_abort", busy, 0);
    end else begin
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (!load_ready && cnt < 300);
      check("ready_latency", cnt, total + 2);
    end
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [WIDTH-1:0] d;
    logic [LEN_W-1:0] l;
    logic [RPT_W-1:0] r;
    int               ab;
    bit               kv;
    burst_t           b;

    repeat (2) @(negedge clk);
    check("rst_out_seq", out_seq, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_load_ready", load_ready, 0);
    rst = 1'b1;
    #1 check("ready_before_edge", load_ready, 0);
    @(negedge clk);
    check("ready_after_release", load_ready, 1);

    send(8'h05, 4'd3, 4'd0, -1, 1'b0);   // 101 once
    send(8'h05, 4'd3, 4'd1, -1, 1'b0);   // 101101
    send(8'h02, 4'd2, 4'd2, -1, 1'b0);   // 101010
    send(8'hA5, 4'd0, 4'd0, -1, 1'b0);   // len 0 clamps to 8
    send(8'h3C, 4'd12, 4'd0, -1, 1'b0);  // len > WIDTH clamps to 8
    send(8'h01, 4'd1, 4'd2, -1, 1'b0);   // single bit repeated
    send(8'hC3, 4'd8, 4'd0, -1, 1'b1);   // load_valid held through SHIFT
    send(8'h06, 4'd3, 4'd1, -1, 1'b1);
    send(8'h0D, 4'd4, 4'd0, -1, 1'b0);
    send(8'hE7, 4'd8, 4'd0, 2, 1'b0);    // abort on 3rd bit
    send(8'h05, 4'd3, 4'd0, 2, 1'b0);    // abort on final bit beats completion
    send(8'h09, 4'd4, 4'd2, 5, 1'b0);    // abort in second pass

    // abort while idle has no effect
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("idle_abort_ready", load_ready, 1);
    check("idle_abort_busy", busy, 0);
    check("idle_abort_valid", out_valid, 0);

    // asynchronous reset while the 4th bit is on the line
    load_valid = 1'b1;
    load_data  = 8'hB6;
    load_len   = 4'd8;
    load_rpt   = 4'd0;
    b.n = 3; b.done = 1'b0; b.ready = 1'b0; b.det = count_101(8'hB6, 8, 3);
    for (int i = 0; i < 3; i++) exp_bits.push_back(exp_bit(8'hB6, 8, i));
    exp_end.push_back(b);
    @(posedge clk); #1 load_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_out_seq", out_seq, 0);
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    check("async_rst_ready", load_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 check("ready_held_after_release", load_ready, 0);
    @(negedge clk);
    check("ready_one_edge_after_release", load_ready, 1);

    repeat (40) begin
      d  = WIDTH'($urandom);
      l  = LEN_W'($urandom_range(0, 15));
      r  = RPT_W'($urandom_range(0, 3));
      ab = -1;
      if ($urandom_range(0, 3) == 0)
        ab = int'($urandom_range(0, clamp_len(l) * (int'(r) + 1) - 1));
      kv = (ab < 0) && ($urandom_range(0, 1) == 1);
      send(d, l, r, ab, kv);
      if (!kv) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    send(WIDTH'($urandom), 4'd5, 4'd1, -1, 1'b0);

    repeat (5) @(negedge clk);
    check("bits_left_in_queue", exp_bits.size(), 0);
    check("bursts_left_in_queue", exp_end.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
